// File: rtl/fight_display_ctrl.sv
// fight_display_ctrl: frame-shadowed N-player fight overlay with START/PLAY/END phase FSM and a
// 2-stage priority compositor. Define ROUND_TIMER_EN to build the per-round frame countdown.
module fight_display_ctrl #(
  parameter int          N_PLAYERS     = 2,
  parameter int          HEALTH_W      = 3,
  parameter int          SABER_SIZE    = 16,
  parameter int          HB_X0         = 200,
  parameter int          HB_PITCH      = 360,
  parameter int          HB_Y          = 20,
  parameter int          HB_H          = 16,
  parameter int          HB_UNIT       = 20,
  parameter int          BORDER_X      = 960,
  parameter int          BORDER_Y      = 640,
  parameter logic [95:0] PLAYER_COLORS = {24'hFF00FF, 24'h00FF00, 24'h0000FF, 24'hFF0000},
  parameter int          ROUND_FRAMES  = 3600,
  localparam int         WW            = $clog2(N_PLAYERS + 1)
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  input  logic                          nf_in,
  input  logic                          start_in,
  input  logic                          restart_in,
  input  logic                          camera_en_in,
  input  logic [23:0]                   camera_pixel_in,
  input  logic [12*N_PLAYERS-1:0]       box_x_in,
  input  logic [12*N_PLAYERS-1:0]       box_xmax_in,
  input  logic [11*N_PLAYERS-1:0]       box_y_in,
  input  logic [11*N_PLAYERS-1:0]       box_ymax_in,
  input  logic [12*N_PLAYERS-1:0]       saber_x_in,
  input  logic [11*N_PLAYERS-1:0]       saber_y_in,
  input  logic [2*N_PLAYERS-1:0]        saber_state_in,
  input  logic [HEALTH_W*N_PLAYERS-1:0] health_in,
  output logic [23:0]                   pixel_out,
  output logic [1:0]                    phase_out,
  output logic [WW-1:0]                 winner_out,
  output logic [15:0]                   frames_left_out
);

  // state    | meaning
  // ST_START | menu, grey banner, waiting for start_in
  // ST_PLAY  | round running, full layer compositing
  // ST_END   | round over, banner in winner colour, waiting for restart_in
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_END   = 2'd2
  } phase_t;

  function automatic logic [23:0] player_color(input int idx);
    return PLAYER_COLORS[idx*24 +: 24];
  endfunction

  function automatic logic [23:0] saber_color(input logic [1:0] st);
    case (st)
      2'd0:    return 24'hFFFFFF;
      2'd1:    return 24'h00FF00;
      2'd2:    return 24'h0000FF;
      default: return 24'hFFFF00;
    endcase
  endfunction

  logic [11:0]         sh_box_x    [N_PLAYERS];
  logic [11:0]         sh_box_xmax [N_PLAYERS];
  logic [10:0]         sh_box_y    [N_PLAYERS];
  logic [10:0]         sh_box_ymax [N_PLAYERS];
  logic [11:0]         sh_saber_x  [N_PLAYERS];
  logic [10:0]         sh_saber_y  [N_PLAYERS];
  logic [1:0]          sh_saber_st [N_PLAYERS];
  logic [HEALTH_W-1:0] sh_health   [N_PLAYERS];
  logic                loaded;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      loaded <= 1'b0;
      for (int k = 0; k < N_PLAYERS; k++) begin
        sh_box_x[k]    <= '0;
        sh_box_xmax[k] <= '0;
        sh_box_y[k]    <= '0;
        sh_box_ymax[k] <= '0;
        sh_saber_x[k]  <= '0;
        sh_saber_y[k]  <= '0;
        sh_saber_st[k] <= '0;
        sh_health[k]   <= '0;
      end
    end else begin
      loaded <= nf_in;
      if (nf_in) begin
        for (int k = 0; k < N_PLAYERS; k++) begin
          sh_box_x[k]    <= box_x_in[k*12 +: 12];
          sh_box_xmax[k] <= box_xmax_in[k*12 +: 12];
          sh_box_y[k]    <= box_y_in[k*11 +: 11];
          sh_box_ymax[k] <= box_ymax_in[k*11 +: 11];
          sh_saber_x[k]  <= saber_x_in[k*12 +: 12];
          sh_saber_y[k]  <= saber_y_in[k*11 +: 11];
          sh_saber_st[k] <= saber_state_in[k*2 +: 2];
          sh_health[k]   <= health_in[k*HEALTH_W +: HEALTH_W];
        end
      end
    end
  end

  // Winner candidates evaluated from the shadow health of the last loaded frame.
  logic [2:0]    alive_cnt;
  logic [WW-1:0] alive_idx;

  always_comb begin
    alive_cnt = 3'd0;
    alive_idx = '0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      if (sh_health[k] != '0) begin
        alive_cnt = alive_cnt + 3'd1;
        alive_idx = WW'(k + 1);
      end
    end
  end

`ifdef ROUND_TIMER_EN
  logic [HEALTH_W-1:0] best_hp;
  logic [WW-1:0]       best_idx;
  logic                best_tie;

  always_comb begin
    best_hp  = '0;
    best_idx = '0;
    best_tie = 1'b0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      if (k == 0 || sh_health[k] > best_hp) begin
        best_hp  = sh_health[k];
        best_idx = WW'(k + 1);
        best_tie = 1'b0;
      end else if (sh_health[k] == best_hp) begin
        best_tie = 1'b1;
      end
    end
  end

  logic [15:0] frames_left, next_frames;
`endif

  phase_t        phase, next_phase;
  logic [WW-1:0] winner, next_winner;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase  <= ST_START;
      winner <= '0;
    end else begin
      phase  <= next_phase;
      winner <= next_winner;
    end
  end

  always_comb begin
    next_phase  = phase;
    next_winner = winner;
`ifdef ROUND_TIMER_EN
    next_frames = frames_left;
`endif
    case (phase)
      ST_START: begin
        if (start_in) begin
          next_phase  = ST_PLAY;
          next_winner = '0;
`ifdef ROUND_TIMER_EN
          next_frames = 16'(ROUND_FRAMES);
`endif
        end
      end
      ST_PLAY: begin
`ifdef ROUND_TIMER_EN
        if (nf_in && frames_left != 16'd0) next_frames = frames_left - 16'd1;
`endif
        // Health outcome wins over timeout when both are seen on the same frame.
        if (loaded && alive_cnt <= 3'd1) begin
          next_phase  = ST_END;
          next_winner = (alive_cnt == 3'd1) ? alive_idx : '0;
        end
`ifdef ROUND_TIMER_EN
        else if (loaded && frames_left == 16'd0) begin
          next_phase  = ST_END;
          next_winner = best_tie ? '0 : best_idx;
        end
`endif
      end
      ST_END: begin
        if (restart_in) next_phase = ST_START;
      end
      default: next_phase = ST_START;
    endcase
  end

`ifdef ROUND_TIMER_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) frames_left <= '0;
    else           frames_left <= next_frames;
  end

  assign frames_left_out = frames_left;
`else
  assign frames_left_out = 16'd0;
`endif

  assign phase_out  = phase;
  assign winner_out = winner;

  // Stage 1: per-layer hit detection; 13-bit bounds so edge-of-screen sums never wrap.
  logic [12:0] h13, v13;
  logic        border_hit, saber_hit, hb_hit, box_hit, banner_hit;
  logic [23:0] saber_col, hb_col, box_col;

  always_comb begin
    h13        = {2'b00, hcount_in};
    v13        = {3'b000, vcount_in};
    border_hit = (h13 == 13'(BORDER_X) && v13 <= 13'(BORDER_Y)) ||
                 (v13 == 13'(BORDER_Y) && h13 <= 13'(BORDER_X));
    banner_hit = (h13 >= 13'd320) && (h13 <= 13'd639) && (v13 >= 13'd240) && (v13 <= 13'd399);
    saber_hit  = 1'b0;
    hb_hit     = 1'b0;
    box_hit    = 1'b0;
    saber_col  = 24'h000000;
    hb_col     = 24'h000000;
    box_col    = 24'h000000;
    // Descending scan so the lowest player index is the one left standing.
    for (int k = N_PLAYERS - 1; k >= 0; k--) begin
      if (h13 >= {1'b0, sh_saber_x[k]} && h13 < {1'b0, sh_saber_x[k]} + 13'(SABER_SIZE) &&
          v13 >= {2'b00, sh_saber_y[k]} && v13 < {2'b00, sh_saber_y[k]} + 13'(SABER_SIZE)) begin
        saber_hit = 1'b1;
        saber_col = saber_color(sh_saber_st[k]);
      end
      if (h13 >= 13'(HB_X0 + k*HB_PITCH) &&
          h13 < 13'(HB_X0 + k*HB_PITCH) + 13'(sh_health[k]) * 13'(HB_UNIT) &&
          v13 >= 13'(HB_Y) && v13 < 13'(HB_Y + HB_H)) begin
        hb_hit = 1'b1;
        hb_col = player_color(k);
      end
      if (h13 >= {1'b0, sh_box_x[k]} && h13 <= {1'b0, sh_box_xmax[k]} &&
          v13 >= {2'b00, sh_box_y[k]} && v13 <= {2'b00, sh_box_ymax[k]}) begin
        box_hit = 1'b1;
        box_col = player_color(k);
      end
    end
  end

  logic          s1_border, s1_saber, s1_hb, s1_box, s1_banner, s1_cam_en;
  logic [23:0]   s1_saber_col, s1_hb_col, s1_box_col, s1_cam;
  phase_t        s1_phase;
  logic [WW-1:0] s1_winner;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_border    <= 1'b0;
      s1_saber     <= 1'b0;
      s1_hb        <= 1'b0;
      s1_box       <= 1'b0;
      s1_banner    <= 1'b0;
      s1_cam_en    <= 1'b0;
      s1_saber_col <= '0;
      s1_hb_col    <= '0;
      s1_box_col   <= '0;
      s1_cam       <= '0;
      s1_phase     <= ST_START;
      s1_winner    <= '0;
    end else begin
      s1_border    <= border_hit;
      s1_saber     <= saber_hit;
      s1_hb        <= hb_hit;
      s1_box       <= box_hit;
      s1_banner    <= banner_hit;
      s1_cam_en    <= camera_en_in;
      s1_saber_col <= saber_col;
      s1_hb_col    <= hb_col;
      s1_box_col   <= box_col;
      s1_cam       <= camera_pixel_in;
      s1_phase     <= phase;
      s1_winner    <= winner;
    end
  end

  // Stage 2: priority resolve using the phase captured with this pixel.
  logic [23:0] pix_next;

  always_comb begin
    pix_next = 24'h000000;
    case (s1_phase)
      ST_PLAY: begin
        if (s1_border)      pix_next = 24'hFFFFFF;
        else if (s1_saber)  pix_next = s1_saber_col;
        else if (s1_hb)     pix_next = s1_hb_col;
        else if (s1_box)    pix_next = s1_box_col;
        else if (s1_cam_en) pix_next = s1_cam;
      end
      ST_END: begin
        if (s1_banner)
          pix_next = (s1_winner == '0) ? 24'h808080 : player_color(int'(s1_winner) - 1);
      end
      default: begin
        if (s1_banner) pix_next = 24'h808080;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) pixel_out <= '0;
    else           pixel_out <= pix_next;
  end

endmodule

// File: tb/tb_fight_display_ctrl.sv
// Scoreboard bench for fight_display_ctrl: scans push expected pixels, a monitor pops them two
// cycles later. Build with ROUND_TIMER_EN defined to also exercise the round timer.
module tb_fight_display_ctrl;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [10:0]   hcount = '0;
  logic [9:0]    vcount = '0;
  logic          nf = 1'b0, start = 1'b0, restart = 1'b0, cam_en = 1'b0;
  logic [23:0]   camera = 24'h123456;
  logic [12*N-1:0] box_x = '0, box_xmax = '0, saber_x = '0;
  logic [11*N-1:0] box_y = '0, box_ymax = '0, saber_y = '0;
  logic [2*N-1:0]  saber_st = '0;
  logic [3*N-1:0]  health = '0;
  logic [23:0]   pixel_out;
  logic [1:0]    phase_out;
  logic [1:0]    winner_out;
  logic [15:0]   frames_left_out;

  always #5 clk = ~clk;

  fight_display_ctrl #(.ROUND_FRAMES(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .nf_in(nf), .start_in(start), .restart_in(restart), .camera_en_in(cam_en),
    .camera_pixel_in(camera), .box_x_in(box_x), .box_xmax_in(box_xmax),
    .box_y_in(box_y), .box_ymax_in(box_ymax), .saber_x_in(saber_x), .saber_y_in(saber_y),
    .saber_state_in(saber_st), .health_in(health), .pixel_out(pixel_out),
    .phase_out(phase_out), .winner_out(winner_out), .frames_left_out(frames_left_out)
  );

  typedef struct { string name; logic [23:0] exp; } exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic req = 1'b0, v1 = 1'b0, v2 = 1'b0;

  always @(posedge clk) begin
    v1 <= req;
    v2 <= v1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (v2) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: got %06h with nothing expected", pixel_out);
      end else begin
        e = sb.pop_front();
        if (pixel_out !== e.exp) begin
          errors++;
          $display("FAIL %s: pixel got %06h expected %06h", e.name, pixel_out, e.exp);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic scan(input int h, input int v, input string nm, input logic [23:0] exp);
    @(negedge clk);
    hcount = 11'(h);
    vcount = 10'(v);
    sb.push_back('{name: nm, exp: exp});
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic flush();
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic do_nf();
    @(negedge clk); nf = 1'b1;
    @(negedge clk); nf = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_phase(input logic [1:0] exp, input string nm);
    int n = 0;
    while (phase_out !== exp && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(phase_out), 32'(exp));
  endtask

  task automatic set_player(input int k, input int bx, input int bxm, input int by, input int bym,
                            input int sx, input int sy, input int st, input int hp);
    box_x[k*12 +: 12]    = 12'(bx);
    box_xmax[k*12 +: 12] = 12'(bxm);
    box_y[k*11 +: 11]    = 11'(by);
    box_ymax[k*11 +: 11] = 11'(bym);
    saber_x[k*12 +: 12]  = 12'(sx);
    saber_y[k*11 +: 11]  = 11'(sy);
    saber_st[k*2 +: 2]   = 2'(st);
    health[k*3 +: 3]     = 3'(hp);
  endtask

  task automatic set_health(input int h0, input int h1);
    health[0 +: 3] = 3'(h0);
    health[3 +: 3] = 3'(h1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_phase", 32'(phase_out), 32'd0);
    check("reset_winner", 32'(winner_out), 32'd0);
    check("reset_pixel", 32'(pixel_out), 32'd0);
    check("reset_frames", 32'(frames_left_out), 32'd0);
    rst_n = 1'b1;

    cam_en = 1'b1;
    scan(500, 300, "start_banner", 24'h808080);
    scan(100, 100, "start_outside", 24'h000000);
    scan(320, 240, "start_corner", 24'h808080);
    scan(640, 300, "start_right_out", 24'h000000);
    flush();

    pulse_restart();
    check("restart_in_start_ignored", 32'(phase_out), 32'd0);
    pulse_start();
    wait_phase(2'd1, "start_to_play");
    check("play_winner", 32'(winner_out), 32'd0);

    scan(500, 300, "play_camera", 24'h123456);
    flush();
    cam_en = 1'b0;
    scan(500, 300, "play_cam_off", 24'h000000);
    flush();
    pulse_restart();
    check("restart_in_play_ignored", 32'(phase_out), 32'd1);

    set_player(0, 100, 200, 100, 200, 150, 150, 1, 3);
    set_player(1, 1, 0, 0, 0, 1500, 900, 0, 5);
    do_nf();
    check("play_two_alive", 32'(phase_out), 32'd1);

    cam_en = 1'b1;
    scan(155, 155, "saber0_attack", 24'h00FF00);
    scan(120, 120, "box0", 24'hFF0000);
    scan(201, 120, "box0_right_out", 24'h123456);
    scan(200, 200, "box0_corner", 24'hFF0000);
    flush();
    set_player(0, 100, 200, 100, 200, 0, 0, 2, 3);
    scan(155, 155, "no_nf_hold", 24'h00FF00);
    scan(5, 5, "no_nf_old_saber_pos", 24'h123456);
    flush();

    cam_en = 1'b0;
    scan(200, 25, "hb0_start", 24'hFF0000);
    scan(259, 25, "hb0_end", 24'hFF0000);
    scan(260, 25, "hb0_past", 24'h000000);
    scan(559, 25, "hb1_before", 24'h000000);
    scan(560, 25, "hb1_start", 24'h0000FF);
    scan(659, 25, "hb1_end", 24'h0000FF);
    scan(660, 25, "hb1_past", 24'h000000);
    scan(560, 35, "hb1_bottom", 24'h0000FF);
    scan(560, 36, "hb1_below", 24'h000000);
    scan(960, 100, "border_v", 24'hFFFFFF);
    scan(500, 640, "border_h", 24'hFFFFFF);
    scan(961, 640, "border_h_past", 24'h000000);
    scan(960, 641, "border_v_past", 24'h000000);
    flush();

    set_health(0, 2);
    do_nf();
    wait_phase(2'd2, "health_end");
    check("winner_p1", 32'(winner_out), 32'd2);
    scan(500, 300, "end_banner_p1", 24'h0000FF);
    scan(100, 100, "end_outside", 24'h000000);
    scan(960, 100, "end_border_suppressed", 24'h000000);
    flush();
    pulse_start();
    check("start_in_end_ignored", 32'(phase_out), 32'd2);

    @(negedge clk); start = 1'b1; restart = 1'b1;
    @(negedge clk); start = 1'b0; restart = 1'b0;
    check("both_in_end_restart", 32'(phase_out), 32'd0);

    pulse_start();
    wait_phase(2'd1, "replay");
    check("replay_winner_cleared", 32'(winner_out), 32'd0);
    set_health(0, 0);
    do_nf();
    wait_phase(2'd2, "draw_end");
    check("draw_winner", 32'(winner_out), 32'd0);
    scan(500, 300, "draw_banner", 24'h808080);
    flush();
    pulse_restart();
    check("restart_to_start", 32'(phase_out), 32'd0);

`ifdef ROUND_TIMER_EN
    set_health(3, 3);
    pulse_start();
    wait_phase(2'd1, "timer_play");
    check("timer_loaded", 32'(frames_left_out), 32'd4);
    repeat (3) do_nf();
    check("timer_still_play", 32'(phase_out), 32'd1);
    check("timer_one_left", 32'(frames_left_out), 32'd1);
    do_nf();
    wait_phase(2'd2, "timer_end_tie");
    check("timer_tie_winner", 32'(winner_out), 32'd0);
    check("timer_zero", 32'(frames_left_out), 32'd0);
    pulse_restart();
    set_health(4, 3);
    pulse_start();
    wait_phase(2'd1, "timer_play2");
    repeat (4) do_nf();
    wait_phase(2'd2, "timer_end_max");
    check("timer_max_winner", 32'(winner_out), 32'd1);
    pulse_restart();
    pulse_start();
    wait_phase(2'd1, "play_before_reset");
`else
    set_health(3, 3);
    pulse_start();
    wait_phase(2'd1, "play_no_timer");
    repeat (5) do_nf();
    check("no_timer_stays_play", 32'(phase_out), 32'd1);
    check("no_timer_frames_zero", 32'(frames_left_out), 32'd0);
`endif

    cam_en = 1'b1;
    hcount = 11'd500;
    vcount = 10'd300;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midplay_reset_phase", 32'(phase_out), 32'd0);
    check("midplay_reset_winner", 32'(winner_out), 32'd0);
    check("midplay_reset_pixel", 32'(pixel_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule
